tx_ltssm_os_gen: RTL and testbench



---
 rtl/ltssm_pkg.sv | 37 +++
 rtl/tx_os_builder.sv | 29 ++
 rtl/tx_ltssm_os_gen.sv | 141 ++++++++++++++
 tb/tb_tx_ltssm_os_gen.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ltssm_pkg.sv
// ltssm_pkg: shared LTSSM substate encoding, ordered-set symbols and tx FSM states.
// Define TX_LTSSM_FAST_SIM_EN to cut the Polling.Active minimum from 1024 sets to 16.
package ltssm_pkg;

    localparam logic [3:0] SUB_POLL_ACTIVE   = 4'd1;
    localparam logic [3:0] SUB_POLL_CONFIG   = 4'd2;
    localparam logic [3:0] SUB_CFG_LW_START  = 4'd3;
    localparam logic [3:0] SUB_CFG_LW_ACCEPT = 4'd4;
    localparam logic [3:0] SUB_CFG_LN_WAIT   = 4'd5;
    localparam logic [3:0] SUB_CFG_LN_ACCEPT = 4'd6;
    localparam logic [3:0] SUB_CFG_COMPLETE  = 4'd7;

    localparam logic [7:0] COM    = 8'hBC;
    localparam logic [7:0] PAD    = 8'hF7;
    localparam logic [7:0] N_FTS  = 8'hFF;
    localparam logic [7:0] TS1_ID = 8'h4A;
    localparam logic [7:0] TS2_ID = 8'h45;

`ifdef TX_LTSSM_FAST_SIM_EN
    localparam logic [10:0] POLL_ACTIVE_MIN = 11'd16;
`else
    localparam logic [10:0] POLL_ACTIVE_MIN = 11'd1024;
`endif
    localparam logic [4:0] POST_COUNT = 5'd16;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        POST,
        DONE
    } txState_t;

    function automatic logic isSupported(input logic [3:0] sub);
        return (sub >= SUB_POLL_ACTIVE) && (sub <= SUB_CFG_COMPLETE);
    endfunction

endpackage

// File: rtl/tx_os_builder.sv
// tx_os_builder: formats one lane's 16-symbol TS1/TS2 ordered set.
module tx_os_builder
(
    input  logic         isTs2,
    input  logic         linkPad,
    input  logic         lanePad,
    input  logic [7:0]   linkNumber,
    input  logic [7:0]   laneNumber,
    input  logic [7:0]   rateId,
    input  logic         upConfigureCapability,
    output logic [127:0] laneSet
);
    import ltssm_pkg::*;

    // Symbol k occupies bits [8k+7:8k].
    always_comb begin
        laneSet         = '0;
        laneSet[7:0]    = COM;
        laneSet[15:8]   = linkPad ? PAD : linkNumber;
        laneSet[23:16]  = lanePad ? PAD : laneNumber;
        laneSet[31:24]  = N_FTS;
        laneSet[39:32]  = isTs2 ? {rateId[7], upConfigureCapability, rateId[5:0]} : rateId;
        laneSet[47:40]  = 8'h00;
        for (int k = 6; k < 16; k++) begin
            laneSet[8*k +: 8] = isTs2 ? TS2_ID : TS1_ID;
        end
    end

endmodule

// File: rtl/tx_ltssm_os_gen.sv
// tx_ltssm_os_gen: LTSSM transmit-side TS1/TS2 generator with valid/ready output
// and exit detection. TX_LTSSM_FAST_SIM_EN shortens the Polling.Active minimum.
//
// state | meaning
// IDLE  | nothing presented, waiting for start
// SEND  | presenting sets, waiting for the substate's exit condition
// POST  | rxDone seen in Polling.Config / Config.Complete, counting 16 more sets
// DONE  | one-cycle finish pulse, osValid low
module tx_ltssm_os_gen
#(
    parameter int DEVICETYPE = 0,
    parameter int LANES      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             substate,
    input  logic                   start,
    input  logic                   rxDone,
    input  logic [7:0]             linkNumber,
    input  logic [7:0]             rateId,
    input  logic                   upConfigureCapability,
    input  logic [4:0]             numberOfDetectedLanes,
    input  logic                   osReady,
    output logic                   osValid,
    output logic [LANES*128-1:0]   orderedSets,
    output logic [15:0]            osKMask,
    output logic                   finish,
    output logic [10:0]            sentCount
);
    import ltssm_pkg::*;

    txState_t    state;
    txState_t    stateNext;
    logic [4:0]  postCount;
    logic [4:0]  postNext;
    logic [10:0] sentNext;
    logic [3:0]  subQ;
    logic [7:0]  linkQ;
    logic [7:0]  rateQ;
    logic        upCfgQ;
    logic [4:0]  lanesQ;
    logic        xfer;
    logic        startOk;
    logic        isTs2;
    logic        linkPad;
    logic        lanePad;

    assign osValid  = (state == SEND) || (state == POST);
    assign finish   = (state == DONE);
    assign xfer     = osValid && osReady;
    assign startOk  = start && isSupported(substate);
    assign sentNext = (xfer && (sentCount != 11'h7FF)) ? sentCount + 11'd1 : sentCount;

    assign isTs2   = (subQ == SUB_POLL_CONFIG) || (subQ == SUB_CFG_COMPLETE);
    assign linkPad = (subQ == SUB_POLL_ACTIVE) || (subQ == SUB_POLL_CONFIG) ||
                     ((subQ == SUB_CFG_LW_START) && (DEVICETYPE != 0));
    assign lanePad = (subQ <= SUB_CFG_LW_ACCEPT);
    assign osKMask = osValid ? {13'd0, lanePad, linkPad, 1'b1} : 16'd0;

    // Exit rules use the post-transfer counts so the final set is never repeated.
    always_comb begin
        stateNext = state;
        postNext  = postCount;
        case (state)
            IDLE: ;
            SEND: begin
                case (subQ)
                    SUB_POLL_ACTIVE: begin
                        if (rxDone && (sentNext >= POLL_ACTIVE_MIN)) stateNext = DONE;
                    end
                    SUB_POLL_CONFIG, SUB_CFG_COMPLETE: begin
                        if (rxDone) begin
                            stateNext = POST;
                            postNext  = {4'd0, xfer};
                        end
                    end
                    default: begin
                        if (rxDone) stateNext = DONE;
                    end
                endcase
            end
            POST: begin
                postNext = postCount + {4'd0, xfer};
                if (postNext == POST_COUNT) stateNext = DONE;
            end
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (startOk) begin
            stateNext = SEND;
            postNext  = '0;
        end
    end

    // State, counters and the configuration captured at start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            postCount <= '0;
            sentCount <= '0;
            subQ      <= '0;
            linkQ     <= '0;
            rateQ     <= '0;
            upCfgQ    <= 1'b0;
            lanesQ    <= '0;
        end else begin
            state     <= stateNext;
            postCount <= postNext;
            if (startOk) begin
                sentCount <= '0;
                subQ      <= substate;
                linkQ     <= linkNumber;
                rateQ     <= rateId;
                upCfgQ    <= upConfigureCapability;
                lanesQ    <= numberOfDetectedLanes;
            end else begin
                sentCount <= sentNext;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : gLane
        localparam logic [5:0] LANE_IDX = 6'(i);
        logic [127:0] laneSet;

        tx_os_builder uBuilder (
            .isTs2                 (isTs2),
            .linkPad               (linkPad),
            .lanePad               (lanePad),
            .linkNumber            (linkQ),
            .laneNumber            (8'(i)),
            .rateId                (rateQ),
            .upConfigureCapability (upCfgQ),
            .laneSet               (laneSet)
        );

        assign orderedSets[i*128 +: 128] =
            (osValid && (LANE_IDX < {1'b0, lanesQ})) ? laneSet : 128'd0;
    end

endmodule

// File: tb/tb_tx_ltssm_os_gen.sv
// Self-checking bench for tx_ltssm_os_gen against a table-driven reference model.
module tb_tx_ltssm_os_gen;
    localparam int LANES = 16;
    localparam int DT    = 0;
`ifdef TX_LTSSM_FAST_SIM_EN
    localparam int POLL_MIN = 16;
`else
    localparam int POLL_MIN = 1024;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic [3:0]           substate;
    logic                 start;
    logic                 rxDone;
    logic [7:0]           linkNumber;
    logic [7:0]           rateId;
    logic                 upConfigureCapability;
    logic [4:0]           numberOfDetectedLanes;
    logic                 osReady;
    logic                 osValid;
    logic [LANES*128-1:0] orderedSets;
    logic [15:0]          osKMask;
    logic                 finish;
    logic [10:0]          sentCount;

    int nCmp = 0;
    int nErr = 0;
    int lastSent = 0;
    int capSub;
    logic [7:0] capLink;
    logic [7:0] capRate;
    logic capUp;
    int capLanes;

    tx_ltssm_os_gen #(.DEVICETYPE(DT), .LANES(LANES)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .substate              (substate),
        .start                 (start),
        .rxDone                (rxDone),
        .linkNumber            (linkNumber),
        .rateId                (rateId),
        .upConfigureCapability (upConfigureCapability),
        .numberOfDetectedLanes (numberOfDetectedLanes),
        .osReady               (osReady),
        .osValid               (osValid),
        .orderedSets           (orderedSets),
        .osKMask               (osKMask),
        .finish                (finish),
        .sentCount             (sentCount)
    );

    always #5 clk = ~clk;

    // Expected sets straight from the symbol table: PAD fields, TS id, inactive lanes zero.
    function automatic logic [LANES*128-1:0] expSets(input int sub, input logic [7:0] link,
                                                     input logic [7:0] rate, input logic up,
                                                     input int nLanes);
        logic [LANES*128-1:0] v;
        logic [7:0] b;
        bit ts2;
        v = '0;
        ts2 = (sub == 2) || (sub == 7);
        for (int ln = 0; ln < LANES; ln++) begin
            if (ln < nLanes) begin
                for (int k = 0; k < 16; k++) begin
                    case (k)
                        0: b = 8'hBC;
                        1: b = (sub <= 2 || (sub == 3 && DT == 1)) ? 8'hF7 : link;
                        2: b = (sub <= 4) ? 8'hF7 : 8'(ln);
                        3: b = 8'hFF;
                        4: b = ts2 ? {rate[7], up, rate[5:0]} : rate;
                        5: b = 8'h00;
                        default: b = ts2 ? 8'h45 : 8'h4A;
                    endcase
                    v[ln*128 + k*8 +: 8] = b;
                end
            end
        end
        return v;
    endfunction

    function automatic logic [15:0] expMask(input int sub);
        logic [15:0] m;
        m = 16'h0001;
        if (sub <= 2 || (sub == 3 && DT == 1)) m[1] = 1'b1;
        if (sub <= 4) m[2] = 1'b1;
        return m;
    endfunction

    function automatic int diffLane(input logic [LANES*128-1:0] a, input logic [LANES*128-1:0] b);
        for (int i = 0; i < LANES; i++) begin
            if (a[i*128 +: 128] !== b[i*128 +: 128]) return i;
        end
        return 0;
    endfunction

    // Drives a one-cycle start, then scrambles the data inputs to prove they were captured.
    task automatic pulseStart(input int sub, input logic [7:0] link, input logic [7:0] rate,
                              input logic up, input int lanes);
        substate = 4'(sub);
        linkNumber = link;
        rateId = rate;
        upConfigureCapability = up;
        numberOfDetectedLanes = 5'(lanes);
        start = 1'b1;
        capSub = sub; capLink = link; capRate = rate; capUp = up; capLanes = lanes;
        @(negedge clk);
        start = 1'b0;
        substate = 4'($urandom_range(0, 15));
        linkNumber = 8'($urandom);
        rateId = 8'($urandom);
        upConfigureCapability = 1'($urandom);
        numberOfDetectedLanes = 5'($urandom_range(1, 16));
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; rxDone = 1'b0; osReady = 1'b0;
        substate = '0; linkNumber = '0; rateId = '0; upConfigureCapability = 1'b0;
        numberOfDetectedLanes = 5'd16;
        repeat (3) @(negedge clk);
        nCmp++; if (osValid !== 1'b0) begin nErr++; $display("FAIL reset_osValid got=%b exp=0", osValid); end
        nCmp++; if (orderedSets !== '0) begin nErr++; $display("FAIL reset_orderedSets lane=%0d not zero", diffLane(orderedSets, '0)); end
        nCmp++; if (osKMask !== 16'h0) begin nErr++; $display("FAIL reset_osKMask got=%h exp=0000", osKMask); end
        nCmp++; if (finish !== 1'b0) begin nErr++; $display("FAIL reset_finish got=%b exp=0", finish); end
        nCmp++; if (sentCount !== 11'd0) begin nErr++; $display("FAIL reset_sentCount got=%0d exp=0", sentCount); end
        reset = 1'b0;
        @(negedge clk);
        nCmp++; if (osValid !== 1'b0) begin nErr++; $display("FAIL idle_osValid got=%b exp=0", osValid); end
    endtask

    task automatic test_poll_active();
        int sent; bit expFin; bit got; int l;
        logic [LANES*128-1:0] e;
        sent = 0; expFin = 0; got = 0;
        osReady = 1'b1; rxDone = 1'b1;
        pulseStart(1, 8'($urandom), 8'($urandom), 1'($urandom), 16);
        e = expSets(1, capLink, capRate, capUp, capLanes);
        for (int c = 0; c < POLL_MIN + 20 && !got; c++) begin
            nCmp++; if (finish !== expFin) begin nErr++; $display("FAIL pa_finish cyc=%0d got=%b exp=%b", c, finish, expFin); end
            if (finish === 1'b1) begin
                got = 1;
                nCmp++; if (osValid !== 1'b0) begin nErr++; $display("FAIL pa_validAtFinish got=%b exp=0", osValid); end
            end else begin
                nCmp++; if (osValid !== 1'b1) begin nErr++; $display("FAIL pa_osValid cyc=%0d got=%b exp=1", c, osValid); end
                nCmp++; if (orderedSets !== e) begin nErr++; l = diffLane(orderedSets, e);
                    $display("FAIL pa_data cyc=%0d lane=%0d got=%h exp=%h", c, l, orderedSets[l*128 +: 128], e[l*128 +: 128]); end
                nCmp++; if (osKMask !== 16'h0007) begin nErr++; $display("FAIL pa_kmask got=%h exp=0007", osKMask); end
                nCmp++; if (sentCount !== 11'(sent)) begin nErr++; $display("FAIL pa_sentCount cyc=%0d got=%0d exp=%0d", c, sentCount, sent); end
                if (osReady) sent++;
                expFin = (sent >= POLL_MIN) && rxDone;
            end
            @(negedge clk);
        end
        nCmp++; if (!got) begin nErr++; $display("FAIL pa_timeout finish never seen, sent=%0d", sent); end
        nCmp++; if (sentCount !== 11'(POLL_MIN)) begin nErr++; $display("FAIL pa_finalCount got=%0d exp=%0d", sentCount, POLL_MIN); end
        nCmp++; if (osValid !== 1'b0) begin nErr++; $display("FAIL pa_afterFinish osValid got=%b exp=0", osValid); end
        rxDone = 1'b0;
    endtask

    task automatic test_poll_config();
        int sent; int post; bit armed; bit expFin; bit got; int l;
        logic [LANES*128-1:0] e;
        sent = 0; post = 0; armed = 0; expFin = 0; got = 0;
        osReady = 1'b1; rxDone = 1'b0;
        pulseStart(2, 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(1, 16)));
        e = expSets(2, capLink, capRate, capUp, capLanes);
        for (int c = 0; c < 200 && !got; c++) begin
            rxDone = (sent >= 40);
            nCmp++; if (finish !== expFin) begin nErr++; $display("FAIL pc_finish cyc=%0d got=%b exp=%b", c, finish, expFin); end
            if (finish === 1'b1) begin
                got = 1;
                nCmp++; if (osValid !== 1'b0) begin nErr++; $display("FAIL pc_validAtFinish got=%b exp=0", osValid); end
            end else begin
                nCmp++; if (orderedSets !== e) begin nErr++; l = diffLane(orderedSets, e);
                    $display("FAIL pc_data cyc=%0d lane=%0d got=%h exp=%h", c, l, orderedSets[l*128 +: 128], e[l*128 +: 128]); end
                nCmp++; if (osKMask !== expMask(2)) begin nErr++; $display("FAIL pc_kmask got=%h exp=%h", osKMask, expMask(2)); end
                nCmp++; if (sentCount !== 11'(sent)) begin nErr++; $display("FAIL pc_sentCount cyc=%0d got=%0d exp=%0d", c, sentCount, sent); end
                if (rxDone) armed = 1;
                if (osReady) begin sent++; if (armed) post++; end
                expFin = (post == 16);
            end
            @(negedge clk);
        end
        nCmp++; if (!got) begin nErr++; $display("FAIL pc_timeout finish never seen, post=%0d", post); end
        nCmp++; if (sentCount !== 11'd56) begin nErr++; $display("FAIL pc_finalCount got=%0d exp=56", sentCount); end
        rxDone = 1'b0;
    endtask

    task automatic test_cfg_complete();
        int sent; int post; bit expFin; bit got; int l;
        logic [LANES*128-1:0] e;
        osReady = 1'b1; rxDone = 1'b0;
        pulseStart(7, 8'h03, 8'($urandom), 1'b1, 4);
        e = expSets(7, capLink, capRate, capUp, capLanes);
        for (int c = 0; c < 8; c++) begin
            osReady = 1'($urandom);
            nCmp++; if (orderedSets !== e) begin nErr++; l = diffLane(orderedSets, e);
                $display("FAIL cc_data cyc=%0d lane=%0d got=%h exp=%h", c, l, orderedSets[l*128 +: 128], e[l*128 +: 128]); end
            nCmp++; if (orderedSets[3*128 + 16 +: 8] !== 8'h03) begin nErr++; $display("FAIL cc_lane3sym2 got=%h exp=03", orderedSets[3*128 + 16 +: 8]); end
            nCmp++; if (orderedSets[38] !== 1'b1) begin nErr++; $display("FAIL cc_upcfgBit got=%b exp=1", orderedSets[38]); end
            nCmp++; if (osKMask !== 16'h0001) begin nErr++; $display("FAIL cc_kmask got=%h exp=0001", osKMask); end
            @(negedge clk);
        end
        // Restart mid-SEND with upConfigureCapability cleared, then let it complete.
        osReady = 1'b1;
        pulseStart(7, 8'h03, 8'($urandom), 1'b0, 4);
        e = expSets(7, capLink, capRate, capUp, capLanes);
        rxDone = 1'b1;
        sent = 0; post = 0; expFin = 0; got = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            osReady = 1'($urandom);
            nCmp++; if (finish !== expFin) begin nErr++; $display("FAIL cc_finish cyc=%0d got=%b exp=%b", c, finish, expFin); end
            if (finish === 1'b1) begin
                got = 1;
            end else begin
                nCmp++; if (orderedSets !== e) begin nErr++; l = diffLane(orderedSets, e);
                    $display("FAIL cc_data2 cyc=%0d lane=%0d got=%h exp=%h", c, l, orderedSets[l*128 +: 128], e[l*128 +: 128]); end
                nCmp++; if (orderedSets[38] !== 1'b0) begin nErr++; $display("FAIL cc_upcfgBit0 got=%b exp=0", orderedSets[38]); end
                nCmp++; if (sentCount !== 11'(sent)) begin nErr++; $display("FAIL cc_sentCount cyc=%0d got=%0d exp=%0d", c, sentCount, sent); end
                if (osReady) begin sent++; post++; end
                expFin = (post == 16);
            end
            @(negedge clk);
        end
        nCmp++; if (!got) begin nErr++; $display("FAIL cc_timeout finish never seen, post=%0d", post); end
        nCmp++; if (sentCount !== 11'd16) begin nErr++; $display("FAIL cc_finalCount got=%0d exp=16", sentCount); end
        rxDone = 1'b0;
    endtask

    task automatic test_abort_post();
        int l;
        logic [LANES*128-1:0] e;
        osReady = 1'b1; rxDone = 1'b1;
        pulseStart(7, 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(1, 16)));
        for (int c = 0; c < 6; c++) begin
            nCmp++; if (osValid !== 1'b1 || finish !== 1'b0) begin nErr++; $display("FAIL ab_post cyc=%0d valid=%b finish=%b exp 1/0", c, osValid, finish); end
            @(negedge clk);
        end
        rxDone = 1'b0;
        nCmp++; if (finish !== 1'b0) begin nErr++; $display("FAIL ab_startCycle finish got=%b exp=0", finish); end
        pulseStart(4, 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(1, 16)));
        e = expSets(4, capLink, capRate, capUp, capLanes);
        for (int c = 0; c < 40; c++) begin
            nCmp++; if (finish !== 1'b0) begin nErr++; $display("FAIL ab_staleFinish cyc=%0d got=%b exp=0", c, finish); end
            nCmp++; if (sentCount !== 11'(c)) begin nErr++; $display("FAIL ab_sentCount cyc=%0d got=%0d exp=%0d", c, sentCount, c); end
            nCmp++; if (orderedSets !== e) begin nErr++; l = diffLane(orderedSets, e);
                $display("FAIL ab_data cyc=%0d lane=%0d got=%h exp=%h", c, l, orderedSets[l*128 +: 128], e[l*128 +: 128]); end
            nCmp++; if (osKMask !== expMask(4)) begin nErr++; $display("FAIL ab_kmask got=%h exp=%h", osKMask, expMask(4)); end
            @(negedge clk);
        end
        rxDone = 1'b1;
        @(negedge clk);
        rxDone = 1'b0;
        nCmp++; if (finish !== 1'b1 || osValid !== 1'b0) begin nErr++; $display("FAIL ab_finish finish=%b valid=%b exp 1/0", finish, osValid); end
        nCmp++; if (sentCount !== 11'd41) begin nErr++; $display("FAIL ab_finalCount got=%0d exp=41", sentCount); end
        lastSent = 41;
        @(negedge clk);
    endtask

    task automatic test_lane_widths();
        int sent; int k; int sub; bit expFin; bit got; int l;
        logic [LANES*128-1:0] e;
        for (int it = 0; it < 4; it++) begin
            case ($urandom_range(0, 3))
                0: sub = 3;
                1: sub = 5;
                2: sub = 6;
                default: sub = 4;
            endcase
            k = int'($urandom_range(0, 10));
            sent = 0; expFin = 0; got = 0; rxDone = 1'b0;
            pulseStart(sub, 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(1, 16)));
            e = expSets(sub, capLink, capRate, capUp, capLanes);
            for (int c = 0; c < 30 && !got; c++) begin
                osReady = 1'($urandom);
                rxDone = (c >= k);
                nCmp++; if (finish !== expFin) begin nErr++; $display("FAIL lw_finish sub=%0d cyc=%0d got=%b exp=%b", sub, c, finish, expFin); end
                if (finish === 1'b1) begin
                    got = 1;
                end else begin
                    nCmp++; if (orderedSets !== e) begin nErr++; l = diffLane(orderedSets, e);
                        $display("FAIL lw_data sub=%0d lane=%0d got=%h exp=%h", sub, l, orderedSets[l*128 +: 128], e[l*128 +: 128]); end
                    nCmp++; if (osKMask !== expMask(sub)) begin nErr++; $display("FAIL lw_kmask sub=%0d got=%h exp=%h", sub, osKMask, expMask(sub)); end
                    if (osReady) sent++;
                    if (rxDone) expFin = 1;
                end
                @(negedge clk);
            end
            nCmp++; if (!got) begin nErr++; $display("FAIL lw_timeout sub=%0d", sub); end
            nCmp++; if (sentCount !== 11'(sent)) begin nErr++; $display("FAIL lw_finalCount sub=%0d got=%0d exp=%0d", sub, sentCount, sent); end
            lastSent = sent;
        end
        rxDone = 1'b0;
    endtask

    task automatic test_unsupported();
        osReady = 1'b1; rxDone = 1'b0;
        pulseStart(0, 8'($urandom), 8'($urandom), 1'b0, 16);
        pulseStart(int'($urandom_range(8, 15)), 8'($urandom), 8'($urandom), 1'b0, 16);
        for (int c = 0; c < 4; c++) begin
            nCmp++; if (osValid !== 1'b0) begin nErr++; $display("FAIL un_osValid cyc=%0d got=%b exp=0", c, osValid); end
            nCmp++; if (sentCount !== 11'(lastSent)) begin nErr++; $display("FAIL un_sentCount got=%0d exp=%0d", sentCount, lastSent); end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        int sent; bit expFin; bit got; bit prevStall; int l;
        logic [LANES*128-1:0] e;
        logic [LANES*128-1:0] prevSet;
        sent = 0; expFin = 0; got = 0; prevStall = 0; prevSet = '0;
        rxDone = 1'b1;
        pulseStart(1, 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(1, 16)));
        e = expSets(1, capLink, capRate, capUp, capLanes);
        for (int c = 0; c < 4*POLL_MIN + 200 && !got; c++) begin
            osReady = 1'($urandom);
            nCmp++; if (finish !== expFin) begin nErr++; $display("FAIL st_finish cyc=%0d got=%b exp=%b", c, finish, expFin); end
            if (finish === 1'b1) begin
                got = 1;
            end else begin
                nCmp++; if (orderedSets !== e) begin nErr++; l = diffLane(orderedSets, e);
                    $display("FAIL st_data cyc=%0d lane=%0d got=%h exp=%h", c, l, orderedSets[l*128 +: 128], e[l*128 +: 128]); end
                if (prevStall) begin
                    nCmp++; if (orderedSets !== prevSet) begin nErr++; $display("FAIL st_stable cyc=%0d lane=%0d changed during stall", c, diffLane(orderedSets, prevSet)); end
                end
                nCmp++; if (sentCount !== 11'(sent)) begin nErr++; $display("FAIL st_sentCount cyc=%0d got=%0d exp=%0d", c, sentCount, sent); end
                prevStall = !osReady;
                prevSet = orderedSets;
                if (osReady) sent++;
                expFin = (sent >= POLL_MIN) && rxDone;
            end
            @(negedge clk);
        end
        nCmp++; if (!got) begin nErr++; $display("FAIL st_timeout sent=%0d", sent); end
        nCmp++; if (sentCount !== 11'(POLL_MIN)) begin nErr++; $display("FAIL st_finalCount got=%0d exp=%0d", sentCount, POLL_MIN); end
        rxDone = 1'b0;
    endtask

    task automatic test_reset_mid();
        osReady = 1'b1; rxDone = 1'b0;
        pulseStart(1, 8'($urandom), 8'($urandom), 1'($urandom), 16);
        repeat (20) @(negedge clk);
        nCmp++; if (sentCount !== 11'd20) begin nErr++; $display("FAIL rm_preCount got=%0d exp=20", sentCount); end
        reset = 1'b1;
        @(negedge clk);
        nCmp++; if (osValid !== 1'b0) begin nErr++; $display("FAIL rm_osValid got=%b exp=0", osValid); end
        nCmp++; if (sentCount !== 11'd0) begin nErr++; $display("FAIL rm_sentCount got=%0d exp=0", sentCount); end
        nCmp++; if (finish !== 1'b0) begin nErr++; $display("FAIL rm_finish got=%b exp=0", finish); end
        nCmp++; if (orderedSets !== '0 || osKMask !== 16'h0) begin nErr++; $display("FAIL rm_data kmask=%h exp=0000 and zero sets", osKMask); end
        reset = 1'b0;
        @(negedge clk);
        nCmp++; if (osValid !== 1'b0) begin nErr++; $display("FAIL rm_idle osValid got=%b exp=0", osValid); end
    endtask

    initial begin
        test_reset();
        test_poll_active();
        test_poll_config();
        test_cfg_complete();
        test_abort_post();
        test_lane_widths();
        test_unsupported();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
